hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage CPU. Detects load-use hazards between the
//  ID and EX stages and branch/jump redirects resolved in EX. Drives the PC, IF/ID and
//  ID/EX register enables, the IF/ID flush and the ID/EX bubble (control fields forced 0).

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage CPU. It detects load-use hazards
//   between ID and EX, and branch/jump redirects resolved in EX. From these it
//   drives the PC, IF/ID and ID/EX load enables, the IF/ID flush and the ID/EX
//   bubble. A memory-busy input freezes the pipeline. A small FSM sequences
//   load stalls that last more than one cycle. Two saturating performance
//   counters record stall cycles and redirect events.
//
//   State table
//     state     | meaning
//     S_RUN     | normal flow; redirects and first load-use bubble handled here
//     S_LDSTALL | extra load-use bubbles pending, r_cnt holds how many remain
//
// Ports
//   clk, clr          clock (rising edge), async active-low reset
//   i_id_*            source registers and read flags of the ID instruction
//   i_ex_*            write/load/destination and redirect info of the EX instruction
//   i_mem_busy        memory not ready, freeze everything
//   i_perf_clr        synchronous clear of both performance counters
//   o_pc_en, o_ifid_en, o_idex_en     register load enables
//   o_ifid_flush, o_idex_bubble       NOP/bubble insertion
//   o_stall_cnt, o_flush_cnt          saturating event counters
module hazard_ctrl #(
  parameter int LOAD_DELAY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_memtoreg,
  input  logic [4:0]       i_ex_wreg,
  input  logic             i_ex_branch_taken,
  input  logic             i_ex_jump,
  input  logic             i_mem_busy,
  input  logic             i_perf_clr,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_bubble,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic {S_RUN, S_LDSTALL} state_t;

  localparam logic [3:0] LD_REMAIN = 4'(LOAD_DELAY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_redirect;
  logic w_stall_inc;
  logic w_flush_inc;

  // A load writing $0 never produces a usable value, so it can't cause a hazard.
  assign w_load_use = i_ex_memtoreg & i_ex_regwrite & (i_ex_wreg != 5'd0) &
                      ((i_id_uses_rs & (i_id_rs == i_ex_wreg)) |
                       (i_id_uses_rt & (i_id_rt == i_ex_wreg)));
  assign w_redirect = i_ex_branch_taken | i_ex_jump;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!i_mem_busy) begin
      case (r_state)
        S_RUN: begin
          if (!w_redirect && w_load_use && (LOAD_DELAY > 1)) begin
            w_state_nxt = S_LDSTALL;
            w_cnt_nxt   = LD_REMAIN;
          end
        end
        S_LDSTALL: begin
          // EX holds a bubble here, so redirect inputs are meaningless.
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // Output logic; same-cycle effect on the pipeline registers.
  always_comb begin
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_idex_en     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    if (!clr) begin
      o_pc_en   = 1'b0;
      o_ifid_en = 1'b0;
      o_idex_en = 1'b0;
    end else if (i_mem_busy) begin
      o_pc_en   = 1'b0;
      o_ifid_en = 1'b0;
      o_idex_en = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          // The ID instruction is squashed by a redirect, so its hazard is moot.
          if (w_redirect) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            w_flush_inc   = 1'b1;
          end else if (w_load_use) begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
            w_stall_inc   = 1'b1;
          end
        end
        S_LDSTALL: begin
          o_pc_en       = 1'b0;
          o_ifid_en     = 1'b0;
          o_idex_bubble = 1'b1;
          w_stall_inc   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Performance counters; clear beats increment, increments saturate.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_perf_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic       id_uses_rs, id_uses_rt, ex_regwrite, ex_memtoreg;
  logic       ex_branch_taken, ex_jump, mem_busy, perf_clr;

  // a: LOAD_DELAY=1, b: LOAD_DELAY=3, c: LOAD_DELAY=1 with 4-bit counters
  logic [2:0] pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic [15:0] stall_a, flush_a, stall_b, flush_b;
  logic [3:0]  stall_c, flush_c;

  localparam logic [4:0] C_RUN   = 5'b11010;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_OFF   = 5'b00000;

  localparam int K_CTL = 0, K_STALL = 1, K_FLUSH = 2;

  typedef struct {
    int          sel;
    int          kind;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_DELAY(1), .CNT_W(16)) dut_a (
    .clk(clk), .clr(clr), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
    .i_ex_regwrite(ex_regwrite), .i_ex_memtoreg(ex_memtoreg), .i_ex_wreg(ex_wreg),
    .i_ex_branch_taken(ex_branch_taken), .i_ex_jump(ex_jump),
    .i_mem_busy(mem_busy), .i_perf_clr(perf_clr),
    .o_pc_en(pc_en[0]), .o_ifid_en(ifid_en[0]), .o_ifid_flush(ifid_flush[0]),
    .o_idex_en(idex_en[0]), .o_idex_bubble(idex_bubble[0]),
    .o_stall_cnt(stall_a), .o_flush_cnt(flush_a));

  hazard_ctrl #(.LOAD_DELAY(3), .CNT_W(16)) dut_b (
    .clk(clk), .clr(clr), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
    .i_ex_regwrite(ex_regwrite), .i_ex_memtoreg(ex_memtoreg), .i_ex_wreg(ex_wreg),
    .i_ex_branch_taken(ex_branch_taken), .i_ex_jump(ex_jump),
    .i_mem_busy(mem_busy), .i_perf_clr(perf_clr),
    .o_pc_en(pc_en[1]), .o_ifid_en(ifid_en[1]), .o_ifid_flush(ifid_flush[1]),
    .o_idex_en(idex_en[1]), .o_idex_bubble(idex_bubble[1]),
    .o_stall_cnt(stall_b), .o_flush_cnt(flush_b));

  hazard_ctrl #(.LOAD_DELAY(1), .CNT_W(4)) dut_c (
    .clk(clk), .clr(clr), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
    .i_ex_regwrite(ex_regwrite), .i_ex_memtoreg(ex_memtoreg), .i_ex_wreg(ex_wreg),
    .i_ex_branch_taken(ex_branch_taken), .i_ex_jump(ex_jump),
    .i_mem_busy(mem_busy), .i_perf_clr(perf_clr),
    .o_pc_en(pc_en[2]), .o_ifid_en(ifid_en[2]), .o_ifid_flush(ifid_flush[2]),
    .o_idex_en(idex_en[2]), .o_idex_bubble(idex_bubble[2]),
    .o_stall_cnt(stall_c), .o_flush_cnt(flush_c));

  function automatic logic [15:0] observe(int sel, int kind);
    logic [15:0] r;
    r = '0;
    if (kind == K_CTL)
      r = {11'd0, pc_en[sel], ifid_en[sel], ifid_flush[sel], idex_en[sel], idex_bubble[sel]};
    else if (kind == K_STALL)
      r = (sel == 0) ? stall_a : (sel == 1) ? stall_b : {12'd0, stall_c};
    else
      r = (sel == 0) ? flush_a : (sel == 1) ? flush_b : {12'd0, flush_c};
    return r;
  endfunction

  task automatic expect_v(input int sel, input int kind, input logic [15:0] v, input string tag);
    exp_t e;
    e.sel = sel; e.kind = kind; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_ctl_all(input logic [4:0] c, input string tag);
    for (int s = 0; s < 3; s++) expect_v(s, K_CTL, {11'd0, c}, tag);
  endtask

  // Sample 1 time unit after the driving negedge, then advance to the next negedge.
  task automatic step();
    exp_t e;
    logic [15:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel, e.kind);
      n_assert++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s dut%0d kind%0d: observed %h expected %h", e.tag, e.sel, e.kind, o, e.val);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_wreg = 5'd0;
    ex_branch_taken = 1'b0; ex_jump = 1'b0; mem_busy = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic lw2_hazard();
    idle();
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd2;
    id_rs = 5'd2; id_uses_rs = 1'b1;
  endtask

  initial begin
    idle();
    clr = 1'b0;
    @(negedge clk);
    // reset state
    expect_ctl_all(C_OFF, "reset_ctl");
    expect_v(0, K_STALL, 16'd0, "reset_stall");
    expect_v(2, K_FLUSH, 16'd0, "reset_flush");
    step();
    clr = 1'b1;
    expect_ctl_all(C_RUN, "idle_run");
    step();

    // single load-use hazard
    lw2_hazard();
    expect_ctl_all(C_STALL, "lu_first");
    step();
    idle();
    expect_v(0, K_CTL, {11'd0, C_RUN}, "lu1_release");
    expect_v(0, K_STALL, 16'd1, "lu1_stall_cnt");
    expect_v(1, K_CTL, {11'd0, C_STALL}, "lu3_bubble2");
    step();
    expect_v(1, K_CTL, {11'd0, C_STALL}, "lu3_bubble3");
    expect_v(1, K_STALL, 16'd2, "lu3_cnt2");
    step();
    expect_v(1, K_CTL, {11'd0, C_RUN}, "lu3_release");
    expect_v(1, K_STALL, 16'd3, "lu3_cnt3");
    step();

    // redirect wins over simultaneous load-use
    perf_clr = 1'b1;
    step();
    lw2_hazard();
    ex_branch_taken = 1'b1;
    expect_ctl_all(C_REDIR, "redir_over_lu");
    expect_v(0, K_STALL, 16'd0, "perf_clr_stall");
    step();
    idle();
    expect_v(0, K_FLUSH, 16'd1, "redir_flush_cnt");
    expect_v(0, K_STALL, 16'd0, "redir_no_stall");
    expect_v(1, K_CTL, {11'd0, C_RUN}, "redir_no_ldstall");
    step();

    // mem_busy freeze in the middle of a 3-cycle stall
    perf_clr = 1'b1;
    step();
    lw2_hazard();
    expect_v(1, K_CTL, {11'd0, C_STALL}, "frz_first");
    step();
    idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_v(1, K_CTL, {11'd0, C_OFF}, "frz_ctl_b");
      expect_v(0, K_CTL, {11'd0, C_OFF}, "frz_ctl_a");
      expect_v(1, K_STALL, 16'd1, "frz_stall_hold");
      step();
    end
    idle();
    expect_v(1, K_CTL, {11'd0, C_STALL}, "frz_resume2");
    expect_v(1, K_STALL, 16'd1, "frz_cnt1");
    step();
    expect_v(1, K_CTL, {11'd0, C_STALL}, "frz_resume3");
    expect_v(1, K_STALL, 16'd2, "frz_cnt2");
    step();
    expect_v(1, K_CTL, {11'd0, C_RUN}, "frz_done");
    expect_v(1, K_STALL, 16'd3, "frz_cnt3");
    step();

    // qualification of the hazard compare
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd0;
    id_rs = 5'd0; id_uses_rs = 1'b1;
    expect_ctl_all(C_RUN, "wreg0_no_stall");
    step();
    ex_wreg = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    expect_ctl_all(C_RUN, "rt_unused_no_stall");
    step();
    ex_regwrite = 1'b0; id_uses_rt = 1'b1;
    expect_ctl_all(C_RUN, "no_regwrite_no_stall");
    step();
    ex_regwrite = 1'b1;
    expect_ctl_all(C_STALL, "rt_match_stall");
    step();
    idle();
    expect_v(1, K_CTL, {11'd0, C_STALL}, "rt_b2");
    step();
    expect_v(1, K_CTL, {11'd0, C_STALL}, "rt_b3");
    step();
    expect_v(1, K_CTL, {11'd0, C_RUN}, "rt_done");
    step();

    // counter saturation and perf_clr priority
    perf_clr = 1'b1;
    step();
    idle();
    ex_jump = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expect_v(2, K_CTL, {11'd0, C_REDIR}, "jump_ctl");
      expect_v(2, K_FLUSH, 16'((i > 15) ? 15 : i), "sat_flush_c");
      step();
    end
    idle();
    expect_v(2, K_FLUSH, 16'd15, "sat_final_c");
    expect_v(0, K_FLUSH, 16'd20, "nosat_final_a");
    step();
    ex_jump = 1'b1; perf_clr = 1'b1;
    expect_v(2, K_CTL, {11'd0, C_REDIR}, "clr_jump_ctl");
    step();
    idle();
    expect_v(2, K_FLUSH, 16'd0, "perf_clr_wins_c");
    expect_v(0, K_FLUSH, 16'd0, "perf_clr_wins_a");
    step();

    // reset in the middle of a multi-cycle stall
    lw2_hazard();
    step();
    idle();
    expect_v(1, K_CTL, {11'd0, C_STALL}, "pre_rst_stall");
    step();
    clr = 1'b0;
    expect_ctl_all(C_OFF, "rst_mid_ctl");
    expect_v(1, K_STALL, 16'd0, "rst_mid_cnt");
    step();
    clr = 1'b1;
    expect_v(1, K_CTL, {11'd0, C_RUN}, "rst_abandon");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
